// File: rtl/key_report_decoder_if.sv
// Byte-stream link from the USB host interface into the keyboard report decoder.
interface key_report_decoder_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_sop;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, output byte_sop, input byte_ready);
  modport slave  (input byte_in, input byte_valid, input byte_sop, output byte_ready);
endinterface

// File: rtl/key_report_decoder.sv
// Decodes HID boot-keyboard reports into one held keycode plus modifiers; results land two
// cycles after the last byte, and the single EVAL bubble is the only time byte_ready drops.
module key_report_decoder #(
  parameter bit         HOLD_ON_RELEASE = 1'b0,
  parameter logic [7:0] ERR_CODE        = 8'h01
) (
  input  logic                        Clk,
  input  logic                        Reset,
  key_report_decoder_if.slave         byte_bus,
  output logic [7:0]                  key,
  output logic                        key_strobe,
  output logic [7:0]                  modifiers,
  output logic [7:0]                  report_cnt
);

  typedef enum logic {COLLECT, EVAL} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      mod_buf_q, mod_buf_d;
  logic [5:0][7:0] slot_q, slot_d;
  logic [5:0][7:0] prev_q, prev_d;
  logic [7:0]      key_q, key_d;
  logic [7:0]      mod_q, mod_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            strobe_q, strobe_d;

  logic [5:0]      in_prev;
  logic            discard;
  logic            a_vld, c_vld, keep;
  logic [7:0]      a_key, c_key, sel_key;

  assign byte_bus.byte_ready = (state_q == COLLECT);
  assign key        = key_q;
  assign key_strobe = strobe_q;
  assign modifiers  = mod_q;
  assign report_cnt = cnt_q;

  // Key selection over the fully collected report; ascending loops make the highest slot win.
  always_comb begin
    in_prev = '0;
    discard = 1'b1;
    a_vld   = 1'b0;
    a_key   = 8'h00;
    c_vld   = 1'b0;
    c_key   = 8'h00;
    keep    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        if (slot_q[i] == prev_q[j]) in_prev[i] = 1'b1;
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (slot_q[i] != ERR_CODE) discard = 1'b0;
      if (slot_q[i] != 8'h00) begin
        c_vld = 1'b1;
        c_key = slot_q[i];
        if (!in_prev[i]) begin
          a_vld = 1'b1;
          a_key = slot_q[i];
        end
        if (slot_q[i] == key_q) keep = 1'b1;
      end
    end
    if (a_vld)                sel_key = a_key;
    else if (keep)            sel_key = key_q;
    else if (c_vld)           sel_key = c_key;
    else if (HOLD_ON_RELEASE) sel_key = key_q;
    else                      sel_key = 8'h00;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mod_buf_d = mod_buf_q;
    slot_d    = slot_q;
    prev_d    = prev_q;
    key_d     = key_q;
    mod_d     = mod_q;
    cnt_d     = cnt_q;
    strobe_d  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (byte_bus.byte_valid) begin
          if (byte_bus.byte_sop) begin
            mod_buf_d = byte_bus.byte_in;
            idx_d     = 3'd1;
          end else begin
            if (idx_q == 3'd0) mod_buf_d = byte_bus.byte_in;
            else if (idx_q >= 3'd2) slot_d[idx_q - 3'd2] = byte_bus.byte_in;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = EVAL;
          end
        end
      end
      EVAL: begin
        state_d = COLLECT;
        idx_d   = 3'd0;
        if (!discard) begin
          key_d    = sel_key;
          strobe_d = (sel_key != key_q);
          mod_d    = mod_buf_q;
          prev_d   = slot_q;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= COLLECT;
      idx_q     <= 3'd0;
      mod_buf_q <= 8'h00;
      slot_q    <= '0;
      prev_q    <= '0;
      key_q     <= 8'h00;
      mod_q     <= 8'h00;
      cnt_q     <= 8'h00;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mod_buf_q <= mod_buf_d;
      slot_q    <= slot_d;
      prev_q    <= prev_d;
      key_q     <= key_d;
      mod_q     <= mod_d;
      cnt_q     <= cnt_d;
      strobe_q  <= strobe_d;
    end
  end

endmodule

// File: tb/tb_key_report_decoder.sv
// Directed checks of key_report_decoder; dut_a releases to 00, dut_b holds the key on release.
module tb_key_report_decoder;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] bi = 8'h00;
  logic       bv = 1'b0;
  logic       bs = 1'b0;

  logic [7:0] key_a, mod_a, cnt_a, key_b, mod_b, cnt_b;
  logic       stb_a, stb_b;

  int nvec = 0;
  int nerr = 0;

  key_report_decoder_if if_a ();
  key_report_decoder_if if_b ();

  assign if_a.byte_in = bi;
  assign if_a.byte_valid = bv;
  assign if_a.byte_sop = bs;
  assign if_b.byte_in = bi;
  assign if_b.byte_valid = bv;
  assign if_b.byte_sop = bs;

  key_report_decoder #(.HOLD_ON_RELEASE(1'b0), .ERR_CODE(8'h01)) dut_a (
    .Clk(Clk), .Reset(Reset), .byte_bus(if_a.slave),
    .key(key_a), .key_strobe(stb_a), .modifiers(mod_a), .report_cnt(cnt_a)
  );

  key_report_decoder #(.HOLD_ON_RELEASE(1'b1), .ERR_CODE(8'h01)) dut_b (
    .Clk(Clk), .Reset(Reset), .byte_bus(if_b.slave),
    .key(key_b), .key_strobe(stb_b), .modifiers(mod_b), .report_cnt(cnt_b)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sop);
    int n;
    bi = b;
    bs = sop;
    bv = 1'b1;
    n = 0;
    while (!if_a.byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (!if_a.byte_ready) chk("rdy_wait", {31'd0, if_a.byte_ready}, 32'd1);
    tick();
    bv = 1'b0;
    bs = 1'b0;
  endtask

  // Returns one cycle after the last byte transfer (cycle N+1).
  task automatic send_report(input logic [63:0] r, input logic use_sop);
    for (int k = 0; k < 8; k++) send_byte(r[63-8*k -: 8], use_sop && (k == 0));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    tick();
    do_reset();
    chk("rst_key", key_a, 8'h00);
    chk("rst_stb", stb_a, 1'b0);
    chk("rst_mod", mod_a, 8'h00);
    chk("rst_cnt", cnt_a, 8'h00);
    chk("rst_rdy", if_a.byte_ready, 1'b1);

    send_report(64'h00_00_52_00_00_00_00_00, 1'b1);
    chk("t1_rdy_n1", if_a.byte_ready, 1'b0);
    tick();
    chk("t1_key", key_a, 8'h52);
    chk("t1_stb", stb_a, 1'b1);
    chk("t1_cnt", cnt_a, 8'd1);
    chk("t1_rdy_n2", if_a.byte_ready, 1'b1);
    tick();
    chk("t1_stb_n3", stb_a, 1'b0);

    send_report(64'h00_00_00_00_00_00_00_00, 1'b1);
    tick();
    chk("t2_key_a", key_a, 8'h00);
    chk("t2_stb_a", stb_a, 1'b1);
    chk("t2_cnt", cnt_a, 8'd2);
    chk("t2_key_b", key_b, 8'h52);
    chk("t2_stb_b", stb_b, 1'b0);

    send_report(64'h00_00_4F_00_00_00_00_00, 1'b1);
    tick();
    chk("t3_key", key_a, 8'h4F);
    send_report(64'h00_00_4F_50_00_00_00_00, 1'b1);
    tick();
    chk("t4_key", key_a, 8'h50);
    chk("t4_stb", stb_a, 1'b1);
    send_report(64'h00_00_50_00_00_00_00_00, 1'b1);
    tick();
    chk("t5_key", key_a, 8'h50);
    chk("t5_stb", stb_a, 1'b0);
    send_report(64'h00_00_4F_00_00_00_00_00, 1'b1);
    tick();
    chk("t6_key", key_a, 8'h4F);
    chk("t6_stb", stb_a, 1'b1);
    chk("t6_cnt", cnt_a, 8'd6);

    send_report(64'h00_00_51_00_00_00_00_00, 1'b1);
    tick();
    chk("t7_key", key_a, 8'h51);
    chk("t7_cnt", cnt_a, 8'd7);
    send_report(64'h08_00_01_01_01_01_01_01, 1'b1);
    tick();
    chk("t8_key", key_a, 8'h51);
    chk("t8_stb", stb_a, 1'b0);
    chk("t8_cnt", cnt_a, 8'd7);
    chk("t8_mod", mod_a, 8'h00);
    send_report(64'h00_00_51_00_00_00_00_00, 1'b1);
    tick();
    chk("t9_key", key_a, 8'h51);
    chk("t9_stb", stb_a, 1'b0);
    chk("t9_cnt", cnt_a, 8'd8);

    send_byte(8'hAA, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h33, 1'b0);
    send_report(64'h02_00_4F_00_00_00_00_00, 1'b1);
    tick();
    chk("t10_mod", mod_a, 8'h02);
    chk("t10_key", key_a, 8'h4F);
    chk("t10_stb", stb_a, 1'b1);
    chk("t10_cnt", cnt_a, 8'd9);

    // Second report's first byte is offered during EVAL and must wait.
    send_report(64'h00_00_4F_22_00_00_00_00, 1'b1);
    send_report(64'h00_00_22_4F_11_00_00_00, 1'b1);
    tick();
    chk("t11_key", key_a, 8'h11);
    chk("t11_stb", stb_a, 1'b1);
    chk("t11_cnt", cnt_a, 8'd11);

    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    do_reset();
    chk("t12_rst_key", key_a, 8'h00);
    chk("t12_rst_cnt", cnt_a, 8'd0);
    chk("t12_rst_rdy", if_a.byte_ready, 1'b1);
    send_report(64'h00_00_52_00_00_00_00_00, 1'b0);
    tick();
    chk("t12_key", key_a, 8'h52);
    chk("t12_stb", stb_a, 1'b1);
    chk("t12_cnt", cnt_a, 8'd1);
    chk("t12_mod", mod_a, 8'h00);

    send_report(64'h04_00_50_00_00_00_00_00, 1'b1);
    tick();
    chk("t13_key_b", key_b, 8'h50);
    chk("t13_mod_b", mod_b, 8'h04);
    send_report(64'h00_00_00_00_00_00_00_00, 1'b1);
    tick();
    chk("t13_hold_key_b", key_b, 8'h50);
    chk("t13_hold_stb_b", stb_b, 1'b0);
    chk("t13_hold_mod_b", mod_b, 8'h00);
    chk("t13_hold_cnt_b", cnt_b, 8'd3);
    chk("t13_rel_key_a", key_a, 8'h00);
    chk("t13_rel_stb_a", stb_a, 1'b1);

    send_report(64'h00_00_33_33_33_00_00_00, 1'b1);
    tick();
    chk("t14_key_a", key_a, 8'h33);
    chk("t14_key_b", key_b, 8'h33);
    chk("t14_stb_b", stb_b, 1'b1);
    chk("t14_cnt", cnt_a, 8'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
